// File: rtl/shift_amount_detector_if.sv
// Request/result bundle for the shift-amount detector.
// The master issues searches; the slave (the detector) returns results.
interface shift_amount_detector_if #(
    parameter int WIDTH = 8,
    parameter int SW    = 3
);
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;
    logic             found;
    logic [SW-1:0]    n;
    logic             lr;

    modport master (
        output start, in_data, out_data,
        input  busy, done, found, n, lr
    );

    modport slave (
        input  start, in_data, out_data,
        output busy, done, found, n, lr
    );
endinterface

// File: rtl/shift_amount_detector.sv
// Sequential inverse of the logical barrel shifter: walks one (amount, direction)
// candidate per cycle and reports the first one that maps in_data onto out_data.
module shift_amount_detector #(
    parameter int WIDTH = 8,
    parameter int SW    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shift_amount_detector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [SW:0] LAST_K = (SW+1)'(2*WIDTH-2);

    state_t           state_q, state_d;
    logic [SW:0]      k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             found_q, found_d;
    logic [SW-1:0]    n_q, n_d;
    logic             lr_q, lr_d;

    // Candidate k: odd k = left by (k+1)/2, even k = right by k/2, k=0 is n=0 right.
    logic [SW:0]      k_up;
    logic [SW-1:0]    cand_n;
    logic             cand_lr;
    logic [WIDTH-1:0] cand_val;
    logic             match;

    always_comb begin
        k_up     = k_q + {{SW{1'b0}}, k_q[0]};
        cand_n   = k_up[SW:1];
        cand_lr  = k_q[0];
        cand_val = cand_lr ? (a_q << cand_n) : (a_q >> cand_n);
        match    = (cand_val == b_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            found_q <= 1'b0;
            n_q     <= '0;
            lr_q    <= 1'b0;
        end else begin
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            found_q <= found_d;
            n_q     <= n_d;
            lr_q    <= lr_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        found_d = found_q;
        n_d     = n_q;
        lr_d    = lr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.in_data;
                    b_d     = bus.out_data;
                    k_d     = '0;
                    found_d = 1'b0;
                    n_d     = '0;
                    lr_d    = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (match) begin
                    found_d = 1'b1;
                    n_d     = cand_n;
                    lr_d    = cand_lr;
                    state_d = DONE;
                end else if (k_q == LAST_K) begin
                    found_d = 1'b0;
                    n_d     = '0;
                    lr_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy  = (state_q == SEARCH);
        bus.done  = (state_q == DONE);
        bus.found = found_q;
        bus.n     = n_q;
        bus.lr    = lr_q;
    end
endmodule

// File: tb/tb_shift_amount_detector.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor checks results.
module tb_shift_amount_detector;
    localparam int W  = 8;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    shift_amount_detector_if #(.WIDTH(W), .SW(SW)) bus();

    shift_amount_detector #(.WIDTH(W), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       f;
        logic [2:0] n;
        logic       lr;
        int         cap;
        int         dcyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: scan shift candidates in search order with plain arithmetic.
    function automatic void model(input int a, input int b, output logic f,
                                  output int nn, output logic l, output int k);
        f = 1'b0; nn = 0; l = 1'b0; k = 2*W-2;
        for (int m = 0; m < W; m++) begin
            if (m == 0) begin
                if (!f && a == b) begin f = 1'b1; nn = 0; l = 1'b0; k = 0; end
            end else begin
                if (!f && ((a * (1 << m)) % (1 << W)) == b) begin
                    f = 1'b1; nn = m; l = 1'b1; k = 2*m-1;
                end
                if (!f && (a / (1 << m)) == b) begin
                    f = 1'b1; nn = m; l = 1'b0; k = 2*m;
                end
            end
        end
    endfunction

    task automatic search(input logic [7:0] a, input logic [7:0] b);
        int   guard = 0;
        exp_t e;
        logic f, l;
        int   nn, k;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        bus.in_data  = a;
        bus.out_data = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        model(int'(a), int'(b), f, nn, l, k);
        e.f = f; e.n = 3'(nn); e.lr = l; e.cap = cyc; e.dcyc = cyc + k + 1;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("found",   int'(bus.found), int'(e.f));
                chk("n",       int'(bus.n),     int'(e.n));
                chk("lr",      int'(bus.lr),    int'(e.lr));
                chk("latency", cyc,             e.dcyc);
                chk("busy_with_done", int'(bus.busy), 0);
            end
        end else if (sb.size() != 0) begin
            if (cyc >= sb[0].dcyc) begin
                chk("timeout", cyc, sb[0].dcyc - 1);
                void'(sb.pop_front());
            end else if (cyc >= sb[0].cap) begin
                chk("busy_in_search", int'(bus.busy), 1);
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.in_data = '0;
        bus.out_data = '0;
        #12;
        chk("rst_busy",  int'(bus.busy),  0);
        chk("rst_done",  int'(bus.done),  0);
        chk("rst_found", int'(bus.found), 0);
        chk("rst_n",     int'(bus.n),     0);
        chk("rst_lr",    int'(bus.lr),    0);
        @(negedge clk);
        rst_n = 1'b1;

        search(8'd16, 8'd64);
        search(8'd16, 8'd4);
        search(8'd7,  8'd56);
        search(8'd7,  8'd0);
        search(8'd0,  8'd0);
        search(8'h81, 8'h03);

        // Restart attempt and input churn mid-search must be ignored
        search(8'd1, 8'h80);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.in_data = 8'hFF;
        bus.out_data = 8'h00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in_data = 8'h3C;

        // Abort mid-search with reset
        search(8'h81, 8'h03);
        repeat (3) @(posedge clk);
        #2;
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  int'(bus.busy),  0);
        chk("abort_done",  int'(bus.done),  0);
        chk("abort_found", int'(bus.found), 0);
        chk("abort_n",     int'(bus.n),     0);
        chk("abort_lr",    int'(bus.lr),    0);
        @(negedge clk);
        rst_n = 1'b1;
        search(8'd16, 8'd64);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            int         sh;
            a  = 8'($urandom_range(0, 255));
            if (i % 4 == 0) a = 8'(1 << $urandom_range(0, 7));
            sh = $urandom_range(0, 7);
            case ($urandom_range(0, 2))
                0:       b = a << sh;
                1:       b = a >> sh;
                default: b = 8'($urandom_range(0, 255));
            endcase
            search(a, b);
        end

        begin
            int guard = 0;
            while (sb.size() != 0 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (sb.size() != 0) chk("drain", sb.size(), 0);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
